fir_ctrl_regs: RTL

- Register file and run-control FSM in the FIR clock domain (domain B).
- Sits directly downstream of the CDC stage: it consumes the synchronised CDC_A / CDC_data / CDC_wr write strobe and returns data_back for read-back.
- Holds the FIR coefficients and run configuration, and sequences start/done with the FIR datapath core.

---
 rtl/fir_regs_pkg.sv | 16 +
 rtl/fir_run_fsm.sv | 51 +++++
 rtl/fir_ctrl_regs.sv | 91 +++++++++
 3 files changed

// File: rtl/fir_regs_pkg.sv
// fir_regs_pkg: shared address map, register bit positions and run-FSM states
// for the FIR control register block.
package fir_regs_pkg;
    localparam logic [5:0] ADDR_CTRL   = 6'h20;
    localparam logic [5:0] ADDR_STATUS = 6'h21;
    localparam logic [5:0] ADDR_NTAPS  = 6'h22;
    localparam logic [5:0] ADDR_SCNT   = 6'h23;
    localparam logic [5:0] ADDR_ID     = 6'h24;
    localparam int CTRL_START    = 0;
    localparam int CTRL_SOFT_CLR = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
endpackage

// File: rtl/fir_run_fsm.sv
// fir_run_fsm: IDLE->ARM->RUN sequencing of the FIR core plus the sticky
// done/err status flags.
module fir_run_fsm
    import fir_regs_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_start_req,
    input  logic i_scnt_zero,
    input  logic i_blocked_wr,
    input  logic i_soft_clr,
    input  logic i_fir_done,
    output logic o_fir_start,
    output logic o_busy,
    output logic o_done,
    output logic o_err
);
    state_t r_state, w_state_nxt;
    logic   r_done, r_err, w_done_nxt, w_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start_req && !i_scnt_zero) w_state_nxt = ARM;
            ARM:     w_state_nxt = RUN;
            RUN:     if (i_fir_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // a new event outranks a simultaneous soft clear
        w_done_nxt = (r_state == RUN && i_fir_done) ? 1'b1 : i_soft_clr ? 1'b0 : r_done;
        w_err_nxt  = (i_blocked_wr || (i_start_req && (o_busy || i_scnt_zero))) ? 1'b1 :
                     i_soft_clr ? 1'b0 : r_err;
    end

    assign o_fir_start = (r_state == ARM);
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;
endmodule

// File: rtl/fir_ctrl_regs.sv
// fir_ctrl_regs: FIR-domain register file (coefficients, run config, status)
// with registered read-back and a registered coefficient port for the core.
module fir_ctrl_regs
    import fir_regs_pkg::*;
#(
    parameter int                MAX_TAPS = 32,
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 6,
    parameter logic [DATA_W-1:0] ID_VALUE = 16'hF1A0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] CDC_A,
    input  logic [DATA_W-1:0] CDC_data,
    input  logic              CDC_wr,
    output logic [DATA_W-1:0] data_back,
    input  logic [4:0]        coef_rd_addr,
    output logic [DATA_W-1:0] coef_rd_data,
    output logic              fir_start,
    output logic [5:0]        fir_num_taps,
    output logic [DATA_W-1:0] fir_sample_cnt,
    input  logic              fir_done,
    output logic              fir_busy,
    output logic              irq
);
    localparam logic [6:0]        MT7 = 7'(MAX_TAPS);
    localparam logic [DATA_W-1:0] MTD = DATA_W'(MAX_TAPS);

    logic [DATA_W-1:0] r_coef [32];
    logic [5:0]        r_ntaps;
    logic [DATA_W-1:0] r_scnt;
    logic              r_irq_en, r_irq;
    logic              w_busy, w_done, w_err, w_is_coef, w_data_wr, w_ctrl_wr, w_blocked;
    logic [5:0]        w_ntaps_in;
    logic [DATA_W-1:0] w_rd;

    assign w_is_coef  = {1'b0, CDC_A} < MT7;
    assign w_data_wr  = CDC_wr && !w_busy;
    assign w_ctrl_wr  = CDC_wr && CDC_A == ADDR_CTRL;
    assign w_blocked  = CDC_wr && w_busy && (w_is_coef || CDC_A == ADDR_NTAPS || CDC_A == ADDR_SCNT);
    assign w_ntaps_in = (CDC_data == '0) ? 6'd1 : (CDC_data > MTD) ? 6'(MAX_TAPS) : CDC_data[5:0];

    // read-back shows post-write data, except STATUS which shows the pre-update flags
    always_comb begin
        w_rd = w_is_coef ? (w_data_wr ? CDC_data : r_coef[CDC_A[4:0]]) :
               (CDC_A == ADDR_CTRL)   ? DATA_W'({(CDC_wr ? CDC_data[CTRL_IRQ_EN] : r_irq_en), 2'b00}) :
               (CDC_A == ADDR_STATUS) ? DATA_W'({w_err, w_done, w_busy}) :
               (CDC_A == ADDR_NTAPS)  ? DATA_W'(w_data_wr ? w_ntaps_in : r_ntaps) :
               (CDC_A == ADDR_SCNT)   ? (w_data_wr ? CDC_data : r_scnt) :
               (CDC_A == ADDR_ID)     ? ID_VALUE : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_coef[i] <= '0;
            r_ntaps      <= 6'(MAX_TAPS);
            r_scnt       <= '0;
            r_irq_en     <= 1'b0;
            r_irq        <= 1'b0;
            data_back    <= '0;
            coef_rd_data <= '0;
        end else begin
            if (w_data_wr && w_is_coef) r_coef[CDC_A[4:0]] <= CDC_data;
            if (w_data_wr && CDC_A == ADDR_NTAPS) r_ntaps <= w_ntaps_in;
            if (w_data_wr && CDC_A == ADDR_SCNT) r_scnt <= CDC_data;
            if (w_ctrl_wr) r_irq_en <= CDC_data[CTRL_IRQ_EN];
            r_irq        <= w_done && r_irq_en;
            data_back    <= w_rd;
            coef_rd_data <= ({2'b00, coef_rd_addr} < MT7) ? r_coef[coef_rd_addr] : '0;
        end
    end

    fir_run_fsm u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start_req (w_ctrl_wr && CDC_data[CTRL_START]),
        .i_scnt_zero (r_scnt == '0),
        .i_blocked_wr(w_blocked),
        .i_soft_clr  (w_ctrl_wr && CDC_data[CTRL_SOFT_CLR]),
        .i_fir_done  (fir_done),
        .o_fir_start (fir_start),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_err       (w_err)
    );

    assign fir_busy       = w_busy;
    assign irq            = r_irq;
    assign fir_num_taps   = r_ntaps;
    assign fir_sample_cnt = r_scnt;
endmodule
